// File: rtl/keypad_operand_entry_pkg.sv
// keypad_pkg
// Shared key codes, the column drive reset pattern and the editing FSM state
// type for the keypad operand entry block.
package keypad_pkg;

    // Key codes produced by the decoder. Digits 0-9 use their own value.
    localparam logic [3:0] KEY_DIG_MAX = 4'h9;
    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_BACK    = 4'hB;
    localparam logic [3:0] KEY_CLEAR   = 4'hC;
    localparam logic [3:0] KEY_D       = 4'hD;
    localparam logic [3:0] KEY_STAR    = 4'hE;
    // '#' has no action and shares the "no key" code.
    localparam logic [3:0] KEY_NONE    = 4'hF;

    // Column drive after reset: column 0 selected.
    localparam logic [3:0] COL_RESET   = 4'b0001;

    typedef enum logic {
        ENTRY = 1'b0,
        VALID = 1'b1
    } entry_state_t;

endpackage

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Drives the one-hot keypad columns, debounces the row inputs and decodes the
// key under the frozen column into a key code.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fila[3:0]        keypad rows, active high
//   col[3:0]         one-hot column drive (registered)
//   key_evt          one-cycle pulse per debounced press (registered)
//   key_code[3:0]    code of the key latched with key_evt (registered)
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

    logic [3:0]       col_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             pressed_r;
    logic             key_evt_r;
    logic [3:0]       key_code_r;

    logic             any_row_s;
    logic             scan_idle_s;
    logic [1:0]       row_idx_s;
    logic [1:0]       col_idx_s;
    logic [3:0]       code_s;

    // Row priority encode, column index and key layout lookup.
    always_comb begin
        any_row_s = |fila;
        row_idx_s = 2'd0;
        col_idx_s = 2'd0;
        code_s    = KEY_NONE;

        // Lowest row wins when several rows are high.
        if (fila[0]) begin
            row_idx_s = 2'd0;
        end else if (fila[1]) begin
            row_idx_s = 2'd1;
        end else if (fila[2]) begin
            row_idx_s = 2'd2;
        end else begin
            row_idx_s = 2'd3;
        end

        case (col_r)
            4'b0001: col_idx_s = 2'd0;
            4'b0010: col_idx_s = 2'd1;
            4'b0100: col_idx_s = 2'd2;
            4'b1000: col_idx_s = 2'd3;
            default: col_idx_s = 2'd0;
        endcase

        case ({row_idx_s, col_idx_s})
            4'b00_00: code_s = 4'h1;
            4'b00_01: code_s = 4'h2;
            4'b00_10: code_s = 4'h3;
            4'b00_11: code_s = KEY_ENTER;
            4'b01_00: code_s = 4'h4;
            4'b01_01: code_s = 4'h5;
            4'b01_10: code_s = 4'h6;
            4'b01_11: code_s = KEY_BACK;
            4'b10_00: code_s = 4'h7;
            4'b10_01: code_s = 4'h8;
            4'b10_10: code_s = 4'h9;
            4'b10_11: code_s = KEY_CLEAR;
            4'b11_00: code_s = KEY_STAR;
            4'b11_01: code_s = 4'h0;
            4'b11_10: code_s = KEY_NONE;
            4'b11_11: code_s = KEY_D;
            default:  code_s = KEY_NONE;
        endcase

        // Scanning only runs when nothing is pressed and no key is latched;
        // a held key or a pending release keeps the column frozen.
        scan_idle_s = !any_row_s && !pressed_r;
    end

    // Column rotation with a per-column dwell of SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r     <= COL_RESET;
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (scan_idle_s) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DIV_W{1'b0}};
                col_r     <= {col_r[2:0], col_r[3]};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
                col_r     <= col_r;
            end
        end else begin
            div_cnt_r <= div_cnt_r;
            col_r     <= col_r;
        end
    end

    // Press/release debounce: DEBOUNCE consecutive samples at the target level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_r  <= {DEB_W{1'b0}};
            pressed_r  <= 1'b0;
            key_evt_r  <= 1'b0;
            key_code_r <= KEY_NONE;
        end else begin
            key_evt_r <= 1'b0;
            if (!pressed_r) begin
                if (any_row_s) begin
                    if (deb_cnt_r == DEB_LAST) begin
                        deb_cnt_r  <= {DEB_W{1'b0}};
                        pressed_r  <= 1'b1;
                        key_evt_r  <= 1'b1;
                        key_code_r <= code_s;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
                    end
                end else begin
                    deb_cnt_r <= {DEB_W{1'b0}};
                end
            end else begin
                if (!any_row_s) begin
                    if (deb_cnt_r == DEB_LAST) begin
                        deb_cnt_r <= {DEB_W{1'b0}};
                        pressed_r <= 1'b0;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DEB_W'(1'b1);
                    end
                end else begin
                    deb_cnt_r <= {DEB_W{1'b0}};
                end
            end
        end
    end

    assign col      = col_r;
    assign key_evt  = key_evt_r;
    assign key_code = key_code_r;

endmodule

// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry
// Keypad front end: scans and debounces a 4x4 keypad, edits a BCD operand with
// digit/backspace/clear/enter keys, converts entered operands to binary and
// offers OPERANDS of them to the arithmetic stage with a valid/ready handshake.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   fila[3:0]         keypad rows (in), col[3:0] one-hot column drive (out)
//   entry_bcd         digits of operand under edit, LSD in [3:0]
//   digit_cnt         number of digits entered
//   op_idx            index of the operand under edit
//   operands          captured binary operands, operand k at [k*W +: W]
//   op_valid/op_ready handshake towards the consumer
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int OPERANDS = 2,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 10000,
    localparam int W       = $clog2(10**DIGITS),
    localparam int BCD_W   = 4 * DIGITS,
    localparam int CNT_W   = $clog2(DIGITS + 1),
    localparam int IDX_W   = $clog2(OPERANDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            fila,
    output logic [3:0]            col,
    output logic [BCD_W-1:0]      entry_bcd,
    output logic [CNT_W-1:0]      digit_cnt,
    output logic [IDX_W-1:0]      op_idx,
    output logic [OPERANDS*W-1:0] operands,
    output logic                  op_valid,
    input  logic                  op_ready
);

    localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPERANDS - 1);

    entry_state_t            state_r, state_n;
    logic [BCD_W-1:0]        entry_bcd_r, bcd_n;
    logic [CNT_W-1:0]        digit_cnt_r, cnt_n;
    logic [IDX_W-1:0]        op_idx_r, idx_n;
    logic [OPERANDS*W-1:0]   operands_r, ops_n;
    logic                    op_valid_r;

    logic                    key_evt_s;
    logic [3:0]              key_code_s;

    // Horner evaluation: value = sum of d_i * 10^i, MSD first.
    function automatic logic [W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
        logic [W-1:0] acc;
        acc = {W{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc * W'(4'd10) + W'(bcd[4*i +: 4]);
        end
        return acc;
    endfunction

    keypad_scan_debounce #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst),
        .fila     (fila),
        .col      (col),
        .key_evt  (key_evt_s),
        .key_code (key_code_s)
    );

    // Editing FSM: next state and next values of all editing registers.
    always_comb begin
        state_n = state_r;
        bcd_n   = entry_bcd_r;
        cnt_n   = digit_cnt_r;
        idx_n   = op_idx_r;
        ops_n   = operands_r;

        case (state_r)
            ENTRY: begin
                if (key_evt_s) begin
                    if (key_code_s <= KEY_DIG_MAX) begin
                        if (digit_cnt_r < DIGITS_C) begin
                            bcd_n = (entry_bcd_r << 3'd4) | BCD_W'(key_code_s);
                            cnt_n = digit_cnt_r + CNT_W'(1'b1);
                        end else begin
                            bcd_n = entry_bcd_r;
                        end
                    end else if (key_code_s == KEY_BACK) begin
                        if (digit_cnt_r != {CNT_W{1'b0}}) begin
                            bcd_n = entry_bcd_r >> 3'd4;
                            cnt_n = digit_cnt_r - CNT_W'(1'b1);
                        end else begin
                            bcd_n = entry_bcd_r;
                        end
                    end else if (key_code_s == KEY_CLEAR) begin
                        bcd_n = {BCD_W{1'b0}};
                        cnt_n = {CNT_W{1'b0}};
                    end else if (key_code_s == KEY_ENTER) begin
                        for (int k = 0; k < OPERANDS; k++) begin
                            if (op_idx_r == IDX_W'(k)) begin
                                ops_n[k*W +: W] = bcd_to_bin(entry_bcd_r);
                            end else begin
                                ops_n[k*W +: W] = operands_r[k*W +: W];
                            end
                        end
                        bcd_n = {BCD_W{1'b0}};
                        cnt_n = {CNT_W{1'b0}};
                        idx_n = op_idx_r + IDX_W'(1'b1);
                        if (op_idx_r == LAST_IDX) begin
                            state_n = VALID;
                        end else begin
                            state_n = ENTRY;
                        end
                    end else begin
                        // '*', '#' and 'D' carry no editing action.
                        state_n = ENTRY;
                    end
                end else begin
                    state_n = ENTRY;
                end
            end
            VALID: begin
                // Keys are ignored here; only the handshake leaves VALID.
                if (op_ready) begin
                    state_n = ENTRY;
                    ops_n   = {(OPERANDS*W){1'b0}};
                    idx_n   = {IDX_W{1'b0}};
                end else begin
                    state_n = VALID;
                end
            end
            default: begin
                state_n = ENTRY;
            end
        endcase
    end

    // Editing state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ENTRY;
            entry_bcd_r <= {BCD_W{1'b0}};
            digit_cnt_r <= {CNT_W{1'b0}};
            op_idx_r    <= {IDX_W{1'b0}};
            operands_r  <= {(OPERANDS*W){1'b0}};
            op_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            entry_bcd_r <= bcd_n;
            digit_cnt_r <= cnt_n;
            op_idx_r    <= idx_n;
            operands_r  <= ops_n;
            op_valid_r  <= (state_n == VALID);
        end
    end

    assign entry_bcd = entry_bcd_r;
    assign digit_cnt = digit_cnt_r;
    assign op_idx    = op_idx_r;
    assign operands  = operands_r;
    assign op_valid  = op_valid_r;

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Parametrised keypad front end for the calculator datapath. It scans a 4x4 matrix keypad, debounces presses and decodes keys, and assembles up to `DIGITS` BCD digits per operand with enter, backspace and clear editing. It captures `OPERANDS` binary operands and presents them together to the arithmetic stage through a valid/ready handshake. It replaces the fixed two-digit, two-operand load chain and adds editing keys, back-pressure and configurable sizes.

## Interface
Parameters:
- `DIGITS`, 3: BCD digits per operand (1..4).
- `OPERANDS`, 2: operands captured per transaction (1..4).
- `SCAN_DIV`, 1000: clk cycles per column while idle (>=2).
- `DEBOUNCE`, 10000: consecutive stable cycles needed for press and for release (>=2).
- Derived `W` = $clog2(10**DIGITS): binary operand width (3 digits gives 10).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous active-low reset.
- `fila`, in, 4: keypad rows, active high; bit r is row r.
- `col`, out, 4: one-hot column drive; bit c is column c.
- `entry_bcd`, out, 4*DIGITS: digits of the operand being edited, LSD in [3:0], for display.
- `digit_cnt`, out, $clog2(DIGITS+1): digits currently entered.
- `op_idx`, out, $clog2(OPERANDS)+1: index of the operand being edited.
- `operands`, out, OPERANDS*W: captured binary operands; operand k occupies [k*W +: W].
- `op_valid`, out, 1: all operands captured.
- `op_ready`, in, 1: consumer accepts the operands.

## Operation
- **Reset values:** `col` = 4'b0001. All other outputs = 0. State = ENTRY.
- **Scanner:**
  - While no key is held (debounced), `col` rotates left every `SCAN_DIV` cycles: 0001, 0010, 0100, 1000, then back to 0001.
  - Rotation freezes while `|fila` = 1, or while a debounce count is in progress.
- **Debounce:**
  - A press event is a one-cycle internal `key_evt`. It fires when `|fila` has been 1 for `DEBOUNCE` consecutive cycles.
  - After a press event, a new event requires `|fila` = 0 for `DEBOUNCE` consecutive cycles. A held key therefore yields exactly one event.
  - A glitch shorter than `DEBOUNCE` cycles yields no event.
- **Decode:** the key code is latched at the event.
  - Layout by row, columns 0..3: row 0 = 1 2 3 A; row 1 = 4 5 6 B; row 2 = 7 8 9 C; row 3 = * 0 # D.
  - If several rows are high, the lowest row index wins.
- **Key actions in ENTRY:**
  - Digit 0-9: if `digit_cnt` < `DIGITS`, shift `entry_bcd` left by 4, insert the digit at the LSD, and increment `digit_cnt`. Otherwise the digit is ignored.
  - B (backspace): shift `entry_bcd` right by 4 and decrement `digit_cnt`. No effect when `digit_cnt` = 0.
  - C (clear): `entry_bcd` = 0, `digit_cnt` = 0.
  - A (enter): convert `entry_bcd` to binary as the sum of d_i*10^i, zero-extended to W, and store it in operand `op_idx`. Then clear `entry_bcd` and `digit_cnt` and increment `op_idx`. Enter with `digit_cnt` = 0 stores 0.
  - *, #, D: ignored.
- **FSM:**
  - ENTRY goes to VALID on enter when `op_idx` = OPERANDS-1.
  - In VALID, `op_valid` = 1 and every key is ignored.
  - VALID goes to ENTRY on the cycle where `op_valid` and `op_ready` are both 1. That transition clears `operands` and `op_idx`.
  - `op_ready` is ignored in ENTRY.
- **Reset mid-operation:** asynchronously discards all partial digits, operands, debounce counts and scan position.

## Timing
- `fila` row goes high at cycle t and stays high: `key_evt` occurs at t+DEBOUNCE.
- Editing registers (`entry_bcd`, `digit_cnt`, `operands`, `op_idx`) update at t+DEBOUNCE+1.
- `op_valid` rises at t+DEBOUNCE+1 for the final enter.
- Handshake completes at the rising edge where both `op_valid` and `op_ready` are 1. `op_valid` = 0 on the next cycle. `operands` hold stable throughout VALID.
- Scan period is 4*SCAN_DIV cycles. A key in column c is seen within one scan period plus `DEBOUNCE`.
- All outputs are registered; there is no combinational path from `fila` or `op_ready` to any output.

## Structure
- Package `keypad_pkg`:
  - Key code constants: `KEY_ENTER`=4'hA, `KEY_BACK`=4'hB, `KEY_CLEAR`=4'hC, `KEY_NONE`=4'hF.
  - FSM state enum `entry_state_t` {ENTRY, VALID}.
- Sub-module `keypad_scan_debounce`: scanner, debounce counter and key decoder. Outputs `col`, `key_evt` and `key_code`. The parent holds the editing FSM, BCD register and operand registers.

## Test plan
Bench settings: DIGITS=3, OPERANDS=2, SCAN_DIV=4, DEBOUNCE=8.
- Press 1,2,3,A then 4,5,A -> `op_valid`=1, operand0=123 (10'd123), operand1=45; `op_ready` pulse -> `op_valid`=0, `op_idx`=0, `operands`=0.
- Press 9,8,7,6 -> `entry_bcd`=12'h987, `digit_cnt`=3; then B -> 12'h098, `digit_cnt`=2; then C -> 0.
- Press A, A with no digits -> both operands 0, `op_valid`=1. Keys pressed in VALID with `op_ready`=0 leave `operands` unchanged.
- Row pulse of 5 cycles -> no event. Key held 100 cycles -> exactly one digit entered. `col` is frozen during the hold.
- Assert `rst`=0 after entering "12" -> all outputs at reset values and `col`=4'b0001 immediately; after release, the next digit starts a fresh operand 0.
- Press *, #, D -> no register changes.
